// File: rtl/bcd_serial_add_ctrl_pkg.sv
// ============================================================================
// Module   : bcd_serial_add_ctrl_pkg
// Brief    : Shared types and constants for the digit-serial BCD adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_serial_add_ctrl_pkg;

    localparam int         BCD_DIGIT_W   = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'h9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_add.sv
// ============================================================================
// Module   : bcd_add
// Brief    : Single-digit BCD adder; invalid digits force 0xF with carry 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_add
    import bcd_serial_add_ctrl_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] in_a,
    input  logic [BCD_DIGIT_W-1:0] in_b,
    input  logic                   in_cin,
    output logic [BCD_DIGIT_W-1:0] out_x,
    output logic                   out_cout
);

    logic                   w_bad;
    logic [BCD_DIGIT_W:0]   w_raw;
    logic [BCD_DIGIT_W-1:0] w_adj;

    assign w_bad = (in_a > BCD_MAX_DIGIT) || (in_b > BCD_MAX_DIGIT);
    assign w_raw = 5'(in_a) + 5'(in_b) + 5'(in_cin);
    // Decimal correction only needs the low nibble: (raw + 6) mod 16.
    assign w_adj = w_raw[BCD_DIGIT_W-1:0] + 4'd6;

    always_comb begin
        out_x    = w_raw[BCD_DIGIT_W-1:0];
        out_cout = 1'b0;
        if (w_bad) begin
            out_x    = 4'hF;
            out_cout = 1'b1;
        end else if (w_raw > 5'd9) begin
            out_x    = w_adj;
            out_cout = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
// ============================================================================
// Module   : bcd_serial_add_ctrl
// Brief    : Digit-serial packed-BCD adder sequencer, LSD first, one shared
//            bcd_add, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_serial_add_ctrl
    import bcd_serial_add_ctrl_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_a,
    input  logic [4*DIGITS-1:0]   in_b,
    input  logic                  in_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_sum,
    output logic                  out_cout,
    output logic                  out_err,
    output logic                  busy
);

    localparam int               W      = BCD_DIGIT_W * DIGITS;
    localparam int               CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIGITS - 1);

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [W-1:0]           r_a_sr;
    logic [W-1:0]           r_b_sr;
    logic [W-1:0]           r_sum_sr;
    logic [W-1:0]           w_sum_shift;
    logic                   r_carry;
    logic                   r_err;
    logic [CNT_W-1:0]       r_cnt;
    logic [BCD_DIGIT_W-1:0] w_x;
    logic                   w_cout;
    logic                   w_dig_err;

    bcd_add u_bcd_add (
        .in_a     (r_a_sr[BCD_DIGIT_W-1:0]),
        .in_b     (r_b_sr[BCD_DIGIT_W-1:0]),
        .in_cin   (r_carry),
        .out_x    (w_x),
        .out_cout (w_cout)
    );

    assign w_dig_err = (r_a_sr[BCD_DIGIT_W-1:0] > BCD_MAX_DIGIT) ||
                       (r_b_sr[BCD_DIGIT_W-1:0] > BCD_MAX_DIGIT);

    // New digit enters at the top so the LSD ends up at [3:0] after DIGITS shifts.
    generate
        if (DIGITS == 1) begin : g_one_digit
            assign w_sum_shift = w_x;
        end else begin : g_multi_digit
            assign w_sum_shift = {w_x, r_sum_sr[W-1:BCD_DIGIT_W]};
        end
    endgenerate

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (in_valid)        w_state_nx = RUN;
            RUN:     if (r_cnt == C_LAST) w_state_nx = DONE;
            DONE:    if (out_ready)       w_state_nx = IDLE;
            default:                      w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sr  <= in_a;
                        r_b_sr  <= in_b;
                        r_carry <= in_cin;
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sum_sr <= w_sum_shift;
                    r_a_sr   <= r_a_sr >> BCD_DIGIT_W;
                    r_b_sr   <= r_b_sr >> BCD_DIGIT_W;
                    r_carry  <= w_cout;
                    r_err    <= r_err | w_dig_err;
                    if (r_cnt != C_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_sum   = r_sum_sr;
    assign out_cout  = r_carry;
    assign out_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
// ============================================================================
// Module   : tb_bcd_serial_add_ctrl
// Brief    : Directed self-checking bench for the 4-digit and 1-digit builds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, out_err, busy;
    logic [15:0] in_a, in_b, out_sum;

    logic        d1_in_valid, d1_in_ready, d1_in_cin, d1_out_valid, d1_out_ready;
    logic        d1_out_cout, d1_out_err, d1_busy;
    logic [3:0]  d1_in_a, d1_in_b, d1_out_sum;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_serial_add_ctrl #(.DIGITS(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_err   (out_err),
        .busy      (busy)
    );

    bcd_serial_add_ctrl #(.DIGITS(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (d1_in_valid),
        .in_ready  (d1_in_ready),
        .in_a      (d1_in_a),
        .in_b      (d1_in_b),
        .in_cin    (d1_in_cin),
        .out_valid (d1_out_valid),
        .out_ready (d1_out_ready),
        .out_sum   (d1_out_sum),
        .out_cout  (d1_out_cout),
        .out_err   (d1_out_err),
        .busy      (d1_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic op4(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [15:0] es, input logic ec, input logic ee);
        int edges;
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        chk({tag, " ready"}, 32'(in_ready), 32'd1);
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1; edges++;
        end
        chk({tag, " latency"}, 32'(edges), 32'd5);
        chk({tag, " sum"},     32'(out_sum), 32'(es));
        chk({tag, " cout"},    32'(out_cout), 32'(ec));
        chk({tag, " err"},     32'(out_err), 32'(ee));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " valid drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int edges;
        in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; out_ready = 0;
        d1_in_valid = 0; d1_in_a = '0; d1_in_b = '0; d1_in_cin = 0; d1_out_ready = 0;

        #12;
        chk("rst in_ready",  32'(in_ready),  32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst busy",      32'(busy),      32'd0);
        chk("rst sum",       32'(out_sum),   32'd0);
        chk("rst cout",      32'(out_cout),  32'd0);
        chk("rst err",       32'(out_err),   32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op4("basic",   16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        op4("ripple",  16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op4("cin",     16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        op4("invalid", 16'h12A4, 16'h0001, 1'b0, 16'h13F5, 1'b0, 1'b1);

        // Backpressure: result held, new request ignored while in DONE.
        in_a = 16'h1234; in_b = 16'h5678; in_cin = 0; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (4) begin @(posedge clk); #1; end
        chk("bp valid", 32'(out_valid), 32'd1);
        in_a = 16'h1111; in_b = 16'h2222; in_valid = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("bp hold valid", 32'(out_valid), 32'd1);
            chk("bp hold sum",   32'(out_sum),   32'h6912);
            chk("bp hold ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("bp release busy",  32'(busy),     32'd0);
        chk("bp release ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 0;
        chk("bp accept busy", 32'(busy), 32'd1);
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1; edges++;
        end
        chk("bp next latency", 32'(edges),   32'd5);
        chk("bp next sum",     32'(out_sum), 32'h3333);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;

        // Asynchronous reset two cycles into RUN.
        in_a = 16'h4321; in_b = 16'h1111; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (2) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst in_ready",  32'(in_ready),  32'd1);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst busy",      32'(busy),      32'd0);
        chk("midrst sum",       32'(out_sum),   32'd0);
        #1 rst_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        chk("midrst no result", 32'(out_valid), 32'd0);
        op4("post rst", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);

        // Single-digit build.
        d1_in_a = 4'h9; d1_in_b = 4'h9; d1_in_cin = 1; d1_in_valid = 1;
        @(posedge clk); #1;
        d1_in_valid = 0;
        edges = 1;
        while (!d1_out_valid && edges < 20) begin
            @(posedge clk); #1; edges++;
        end
        chk("d1 latency", 32'(edges),       32'd2);
        chk("d1 sum",     32'(d1_out_sum),  32'h9);
        chk("d1 cout",    32'(d1_out_cout), 32'd1);
        chk("d1 err",     32'(d1_out_err),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
